ahb_lite_master: RTL and testbench

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/ahb_lite_master.sv | 145 ++++++++++++++
 tb/tb_ahb_lite_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// Purpose : single-outstanding AHB-Lite master; turns one cmd into one NONSEQ SINGLE word transfer.
// Latency : accept at N, address phase N+1, data phase N+2, rsp_valid at N+3 (+ wait/error cycles).
// Backpr. : cmd_ready is high only in IDLE; hready low stretches the address or data phase.
//
// Ports:
//   hclk, hreset_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready                 command handshake; cmd_write, cmd_addr, cmd_wdata describe it
//   rsp_valid, rsp_error, rsp_rdata     one-cycle completion pulse with status and read data
//   haddr, htrans, hwrite, hsize,
//   hburst, hwdata                      AHB-Lite master outputs
//   hrdata, hready, hresp               AHB-Lite slave responses
//
// Optional feature: define AHB_MASTER_TIMEOUT_EN to add a data-phase watchdog that ends a
// transfer with rsp_error=1 after TIMEOUT_CYCLES wait cycles. Without it the master waits forever.
module ahb_lite_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              hclk,
   input  logic              hreset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_error,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_ERR  = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic              w_rsp_err;
   logic              w_timeout;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;

`ifdef AHB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_wd_cnt;

   // Fires on the wait cycle that brings the count up to TIMEOUT_CYCLES.
   assign w_timeout = ((r_state == S_DATA) || (r_state == S_ERR)) && !hready &&
                      (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         r_wd_cnt <= '0;
      end else if ((r_state == S_ADDR) && hready) begin
         r_wd_cnt <= '0;
      end else if (((r_state == S_DATA) || (r_state == S_ERR)) && !hready) begin
         r_wd_cnt <= r_wd_cnt + 1'b1;
      end
   end
`else
   // No watchdog: the limit only matters when the counter exists, kept referenced here.
   assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      w_next    = r_state;
      w_rsp_err = 1'b0;
      case (r_state)
         S_IDLE: if (cmd_valid) w_next = S_ADDR;
         S_ADDR: if (hready) w_next = S_DATA;
         S_DATA: begin
            if (w_timeout) begin
               w_next    = S_RESP;
               w_rsp_err = 1'b1;
            end else if (hready) begin
               // hready=1 with hresp=1 is a non-compliant one-cycle ERROR; still reported as error.
               w_next    = S_RESP;
               w_rsp_err = hresp;
            end else if (hresp) begin
               w_next = S_ERR;
            end
         end
         S_ERR: begin
            if (hready || w_timeout) begin
               w_next    = S_RESP;
               w_rsp_err = 1'b1;
            end
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         r_state <= S_IDLE;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         // Bus-facing copies only change on acceptance, so they hold through IDLE.
         if ((r_state == S_IDLE) && cmd_valid) begin
            r_write <= cmd_write;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
         end
         if (w_next == S_RESP) begin
            r_err <= w_rsp_err;
         end
         if ((r_state == S_DATA) && hready && !hresp && !r_write) begin
            r_rdata <= hrdata;
         end
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign htrans    = (r_state == S_ADDR) ? 2'b10 : 2'b00;
   assign haddr     = r_addr;
   assign hwrite    = r_write;
   assign hsize     = 3'b010;
   assign hburst    = 3'b000;
   assign hwdata    = r_wdata;
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_error = r_err;
   assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;

   localparam int TO = 8;

   logic        hclk      = 1'b0;
   logic        hreset_n  = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr  = '0;
   logic [31:0] cmd_wdata = '0;
   logic        cmd_ready;
   logic        rsp_valid;
   logic        rsp_error;
   logic [31:0] rsp_rdata;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   logic [31:0] hrdata    = '0;
   logic        hready    = 1'b1;
   logic        hresp     = 1'b0;

   ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .hclk(hclk), .hreset_n(hreset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hwdata(hwdata),
      .hrdata(hrdata), .hready(hready), .hresp(hresp)
   );

   always #5 hclk = ~hclk;

   // mode: 0 OKAY after w waits, 1 two-cycle ERROR after w waits,
   //       2 ERROR with hready=1 after w waits, 3 slave never ready
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          astall;
      int          w;
      int          mode;
   } xfer_t;

   xfer_t       q[$];
   xfer_t       cur;
   int          t = 0;
   bit          pend = 0;
   int          a_t, ae_t, rc_t;
   logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
   logic        e_write = 1'b0;
   int          n_tests = 0, n_fail = 0;
   int          n_acc = 0, n_rsp = 0;
   int          dut_acc_t = 0, dut_rsp_t = 0;
   logic        dut_rsp_err = 1'b0;
   logic [31:0] dut_rsp_rdata = '0;
   int          acc_hist[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
      end
   endtask

   // Cycle of the response pulse given the last address-phase cycle.
   function automatic int rsp_cycle(input int ae, input xfer_t x);
      if (x.mode == 0 || x.mode == 2) return ae + 2 + x.w;
      if (x.mode == 1) return ae + 3 + x.w;
`ifdef AHB_MASTER_TIMEOUT_EN
      return ae + 1 + TO;
`else
      return 32'h7fff_ffff;
`endif
   endfunction

   // Model, compare and slave, all evaluated mid-cycle on the falling edge.
   always @(negedge hclk) begin
      bit fin;
      int d;
      t++;
      if (!hreset_n) begin
         pend = 0;
         q.delete();
         e_addr = '0; e_wdata = '0; e_rdata = '0; e_write = 1'b0;
         hready = 1'b1; hresp = 1'b0; hrdata = '0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            dut_acc_t = t;
            acc_hist.push_back(t);
         end
         if (rsp_valid) begin
            n_rsp++;
            dut_rsp_t     = t;
            dut_rsp_err   = rsp_error;
            dut_rsp_rdata = rsp_rdata;
         end
         fin = pend && (t == rc_t);
         if (fin && !cur.wr && cur.mode == 0) e_rdata = cur.rdata;

         chk("cmd_ready", cmd_ready, !pend);
         chk("htrans", htrans, (pend && t > a_t && t <= ae_t) ? 2 : 0);
         chk("haddr", haddr, e_addr);
         chk("hwrite", hwrite, e_write);
         if (!pend || t > ae_t) chk("hwdata", hwdata, e_wdata);
         chk("hsize", hsize, 3'b010);
         chk("hburst", hburst, 3'b000);
         chk("rsp_valid", rsp_valid, fin);
         if (fin) chk("rsp_error", rsp_error, cur.mode != 0);
         chk("rsp_rdata", rsp_rdata, e_rdata);

         if (!pend && cmd_valid && q.size() > 0) begin
            cur     = q.pop_front();
            pend    = 1;
            a_t     = t;
            ae_t    = t + 1 + cur.astall;
            rc_t    = rsp_cycle(ae_t, cur);
            e_addr  = cur.addr;
            e_write = cur.wr;
            e_wdata = cur.wdata;
            n_acc++;
         end

         hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
         if (pend && t > a_t && t < ae_t) begin
            hready = 1'b0;
         end else if (pend && t > ae_t && t < rc_t) begin
            d = t - ae_t - 1;
            hrdata = ~cur.rdata;
            case (cur.mode)
               0: begin
                  hready = (d >= cur.w);
                  if (d >= cur.w) hrdata = cur.rdata;
               end
               1: begin
                  hready = (d > cur.w);
                  hresp  = (d >= cur.w);
                  hrdata = cur.rdata;
               end
               2: begin
                  hready = (d >= cur.w);
                  hresp  = (d >= cur.w);
                  hrdata = cur.rdata;
               end
               default: hready = 1'b0;
            endcase
         end
         if (fin) pend = 0;
      end
   end

   task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int astall, input int w, input int mode,
                       input bit last);
      xfer_t x;
      int a0, k;
      x.wr = wr; x.addr = addr; x.wdata = wdata; x.rdata = rdata;
      x.astall = astall; x.w = w; x.mode = mode;
      q.push_back(x);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      a0 = n_acc;
      k  = 0;
      while (n_acc == a0 && k < 100) begin
         @(posedge hclk);
         k++;
      end
      #1;
      chk("accept_wait", n_acc != a0, 1);
      if (last) cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while ((pend || q.size() > 0) && k < 2000) begin
         @(posedge hclk);
         k++;
      end
      #1;
      chk("done_wait", pend || q.size() > 0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout t=%0d", t);
      $fatal(1, "bench time limit");
   end

   initial begin
      int c0, n;
      repeat (3) @(posedge hclk);
      #1 hreset_n = 1'b1;
      repeat (2) @(posedge hclk);
      #1;
      chk("reset_ready", cmd_ready, 1);
      chk("reset_htrans", htrans, 0);

      // Zero-wait write.
      send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 1);
      wait_done();
      chk("wr_latency", dut_rsp_t - dut_acc_t, 3);
      chk("wr_err", dut_rsp_err, 0);
      chk("wr_hwdata", hwdata, 32'hDEAD_BEEF);

      // Read with three wait states.
      send(1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 0, 3, 0, 1);
      wait_done();
      chk("rd_latency", dut_rsp_t - dut_acc_t, 6);
      chk("rd_rdata", dut_rsp_rdata, 32'h1234_5678);

      // A write leaves rsp_rdata untouched.
      send(1'b1, 32'h0000_0030, 32'hA5A5_5A5A, 32'h0, 0, 0, 0, 1);
      wait_done();
      chk("wr_keeps_rdata", rsp_rdata, 32'h1234_5678);

      // Two-cycle ERROR on a read.
      send(1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_0BAD, 0, 0, 1, 1);
      wait_done();
      chk("err2_latency", dut_rsp_t - dut_acc_t, 4);
      chk("err2_err", dut_rsp_err, 1);
      chk("err2_rdata", rsp_rdata, 32'h1234_5678);

      // ERROR signalled with hready=1 after one wait.
      send(1'b1, 32'h0000_0044, 32'h0F0F_0F0F, 32'h0, 0, 1, 2, 1);
      wait_done();
      chk("err1_latency", dut_rsp_t - dut_acc_t, 4);
      chk("err1_err", dut_rsp_err, 1);

      // Address phase stretched by two cycles.
      send(1'b0, 32'h0000_0048, 32'h0, 32'hCAFE_F00D, 2, 0, 0, 1);
      wait_done();
      chk("astall_latency", dut_rsp_t - dut_acc_t, 5);
      chk("astall_rdata", dut_rsp_rdata, 32'hCAFE_F00D);
      chk("rsp_count_a", n_rsp, 6);

      // Back-to-back with cmd_valid held high.
      send(1'b1, 32'h0000_0100, 32'h1111_1111, 32'h0, 0, 0, 0, 0);
      send(1'b0, 32'h0000_0104, 32'h0, 32'h2222_2222, 0, 0, 0, 0);
      send(1'b1, 32'h0000_0108, 32'h3333_3333, 32'h0, 0, 0, 0, 0);
      send(1'b0, 32'h0000_010C, 32'h0, 32'h4444_4444, 0, 0, 0, 1);
      wait_done();
      n = acc_hist.size();
      for (int i = n - 3; i < n; i++) chk("b2b_gap", acc_hist[i] - acc_hist[i-1], 4);
      chk("b2b_rdata", dut_rsp_rdata, 32'h4444_4444);
      chk("rsp_count_b", n_rsp, 10);

      // Reset during a data-phase wait state.
      send(1'b0, 32'h0000_0050, 32'h0, 32'h5555_5555, 0, 5, 0, 1);
      repeat (2) @(posedge hclk);
      #1 hreset_n = 1'b0;
      @(posedge hclk);
      #1 hreset_n = 1'b1;
      chk("rst_htrans", htrans, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_rdata", rsp_rdata, 0);
      c0 = n_rsp;
      repeat (20) @(posedge hclk);
      #1;
      chk("rst_no_rsp", n_rsp, c0);

      // Slave that never becomes ready.
      send(1'b0, 32'h0000_0060, 32'h0, 32'h6666_6666, 0, 0, 3, 1);
`ifdef AHB_MASTER_TIMEOUT_EN
      wait_done();
      chk("to_latency", dut_rsp_t - dut_acc_t, 10);
      chk("to_err", dut_rsp_err, 1);
      chk("rsp_count_c", n_rsp, 11);
`else
      c0 = n_rsp;
      repeat (1000) @(posedge hclk);
      #1;
      chk("stuck_no_rsp", n_rsp, c0);
      chk("stuck_busy", cmd_ready, 0);
      hreset_n = 1'b0;
      @(posedge hclk);
      #1 hreset_n = 1'b1;
      chk("rsp_count_c", n_rsp, 10);
`endif

      // Normal operation afterwards.
      send(1'b1, 32'h0000_0070, 32'h7777_7777, 32'h0, 0, 0, 0, 1);
      wait_done();
      send(1'b0, 32'h0000_0074, 32'h0, 32'h8888_8888, 0, 1, 0, 1);
      wait_done();
      chk("final_latency", dut_rsp_t - dut_acc_t, 4);
      chk("final_rdata", dut_rsp_rdata, 32'h8888_8888);

      repeat (3) @(posedge hclk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
